// File: rtl/prf_free_list_pkg.sv
// Shared core package: register-file sizing and the physical register id type,
// also used by the results buffer and the rename stage.
package prf_free_list_pkg;

   localparam int PRF_REGS  = 16;
   localparam int ARCH_REGS = 8;
   localparam int PREG_W    = 4;

   typedef logic [PREG_W-1:0] preg_id_t;

endpackage

// File: rtl/prf_free_list.sv
// Physical register free list: a circular FIFO of free register ids with a
// single head checkpoint for branch-mispredict rollback.
module prf_free_list #(
   parameter int PRF_REGS  = prf_free_list_pkg::PRF_REGS,
   parameter int ARCH_REGS = prf_free_list_pkg::ARCH_REGS
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        alloc_req,
   output logic                        alloc_valid,
   output prf_free_list_pkg::preg_id_t alloc_id,
   input  logic                        retire_transmit,
   input  prf_free_list_pkg::preg_id_t retire_id,
   input  logic                        ckpt_save,
   input  logic                        ckpt_restore,
   output logic [3:0]                  free_count,
   output logic                        err_overflow
);

   localparam int FL_DEPTH = PRF_REGS - ARCH_REGS;
   localparam int IDX_W    = $clog2(FL_DEPTH);
   localparam int PTR_W    = IDX_W + 1;

   localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(FL_DEPTH);
   localparam logic [PTR_W-1:0] ONE_P   = PTR_W'(1);

   prf_free_list_pkg::preg_id_t mem_q [FL_DEPTH];

   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [PTR_W-1:0] ckpt_q, ckpt_d;
   logic             err_q, err_d;
   logic [PTR_W-1:0] count_w;
   logic             alloc_fire;
   logic             retire_fire;

   // Wrap bit makes tail - head distinguish full (FL_DEPTH) from empty (0).
   assign count_w     = tail_q - head_q;
   assign free_count  = 4'(count_w);
   assign alloc_valid = (count_w != '0);
   assign alloc_id    = mem_q[head_q[IDX_W-1:0]];
   assign err_overflow = err_q;

   assign alloc_fire  = alloc_req && alloc_valid && !ckpt_restore;
   assign retire_fire = retire_transmit && (count_w < DEPTH_P);

   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      ckpt_d = ckpt_q;
      err_d  = retire_transmit && !retire_fire;

      if (ckpt_restore) begin
         head_d = ckpt_q;
      end else if (alloc_fire) begin
         head_d = head_q + ONE_P;
      end

      // Restore wins over a same-cycle save; save captures the pre-allocation head.
      if (ckpt_save && !ckpt_restore) begin
         ckpt_d = head_q;
      end

      if (retire_fire) begin
         tail_d = tail_q + ONE_P;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q <= '0;
         tail_q <= DEPTH_P;
         ckpt_q <= '0;
         err_q  <= 1'b0;
         for (int i = 0; i < FL_DEPTH; i++) begin
            mem_q[i] <= prf_free_list_pkg::preg_id_t'(ARCH_REGS + i);
         end
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         ckpt_q <= ckpt_d;
         err_q  <= err_d;
         if (retire_fire) begin
            mem_q[tail_q[IDX_W-1:0]] <= retire_id;
         end
      end
   end

endmodule
